// File: rtl/irrigation_sequencer.sv
// Tick-driven irrigation sequencer: sensor sync/debounce, dead time, bounded run/soak, fault alarm.
// Optional supply-valve fill timeout is enabled by defining FILL_TIMEOUT_EN.
module irrigation_sequencer #(
  parameter int unsigned DEBOUNCE_TICKS     = 3,
  parameter int unsigned RUN_TICKS          = 8,
  parameter int unsigned DEAD_TICKS         = 2,
  parameter int unsigned SOAK_TICKS         = 4,
  parameter int unsigned TIMER_WIDTH        = 8
`ifdef FILL_TIMEOUT_EN
  ,parameter int unsigned FILL_TIMEOUT_TICKS = 16
`endif
) (
  input  logic       clock,
  input  logic       reset_n,
  input  logic       tick,
  input  logic       low_water_level,
  input  logic       mid_water_level,
  input  logic       high_water_level,
  input  logic       earth_humidity,
  input  logic       air_humidity,
  input  logic       low_temperature,
  output logic       water_supply_valvule,
  output logic       splinker_bomb,
  output logic       dripper_valvule,
  output logic       alarm,
  output logic [2:0] state_code
);

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    DEAD     = 3'd1,
    SPRINKLE = 3'd2,
    DRIP     = 3'd3,
    SOAK     = 3'd4,
    FAULT    = 3'd5
  } state_t;

  localparam int unsigned NSENS = 6;
  localparam logic [TIMER_WIDTH-1:0] T_MAX  = '1;
  localparam logic [TIMER_WIDTH-1:0] T_ONE  = TIMER_WIDTH'(1);
  localparam logic [TIMER_WIDTH-1:0] DEB_T  = TIMER_WIDTH'(DEBOUNCE_TICKS);
  localparam logic [TIMER_WIDTH-1:0] RUN_T  = TIMER_WIDTH'(RUN_TICKS);
  localparam logic [TIMER_WIDTH-1:0] DEAD_T = TIMER_WIDTH'(DEAD_TICKS);
  localparam logic [TIMER_WIDTH-1:0] SOAK_T = TIMER_WIDTH'(SOAK_TICKS);

  function automatic logic [TIMER_WIDTH-1:0] sat_inc(input logic [TIMER_WIDTH-1:0] v);
    return (v == T_MAX) ? v : v + T_ONE;
  endfunction

  // Sensor bit order: 0 low, 1 mid, 2 high, 3 earth, 4 air, 5 cold
  logic [NSENS-1:0]       w_raw;
  logic [NSENS-1:0]       r_sync1;
  logic [NSENS-1:0]       r_sync2;
  logic [NSENS-1:0]       r_deb;
  logic [TIMER_WIDTH-1:0] r_dcnt [NSENS];

  assign w_raw = {low_temperature, air_humidity, earth_humidity,
                  high_water_level, mid_water_level, low_water_level};

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      r_sync1 <= '0;
      r_sync2 <= '0;
      r_deb   <= '0;
      for (int unsigned i = 0; i < NSENS; i++) r_dcnt[i] <= '0;
    end else begin
      r_sync1 <= w_raw;
      r_sync2 <= r_sync1;
      if (tick) begin
        for (int unsigned i = 0; i < NSENS; i++) begin
          if (r_sync2[i] != r_deb[i]) begin
            if (sat_inc(r_dcnt[i]) >= DEB_T) begin
              r_deb[i]  <= ~r_deb[i];
              r_dcnt[i] <= '0;
            end else begin
              r_dcnt[i] <= sat_inc(r_dcnt[i]);
            end
          end else begin
            r_dcnt[i] <= '0;
          end
        end
      end
    end
  end

  logic w_low, w_mid, w_high, w_earth, w_air, w_cold, w_conflict;
  assign w_low      = r_deb[0];
  assign w_mid      = r_deb[1];
  assign w_high     = r_deb[2];
  assign w_earth    = r_deb[3];
  assign w_air      = r_deb[4];
  assign w_cold     = r_deb[5];
  assign w_conflict = (w_mid & ~w_low) | (w_high & ~w_mid);

  state_t                 r_state, w_next;
  state_t                 r_mode, w_mode_nx;
  logic [TIMER_WIDTH-1:0] r_timer, w_timer_nx, w_timer_inc;
  logic                   r_valve, r_spk, r_drip, r_alarm;
  logic                   w_fill_fault;

`ifdef FILL_TIMEOUT_EN
  localparam logic [TIMER_WIDTH-1:0] FILL_T = TIMER_WIDTH'(FILL_TIMEOUT_TICKS);
  logic [TIMER_WIDTH-1:0] r_fill_cnt;
  logic                   r_fill_fault;

  // Fault latch is sticky; only reset_n releases it
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      r_fill_cnt   <= '0;
      r_fill_fault <= 1'b0;
    end else if (!r_valve) begin
      r_fill_cnt <= '0;
    end else if (tick) begin
      r_fill_cnt <= sat_inc(r_fill_cnt);
      if (sat_inc(r_fill_cnt) >= FILL_T) r_fill_fault <= 1'b1;
    end
  end
  assign w_fill_fault = r_fill_fault;
`else
  assign w_fill_fault = 1'b0;
`endif

  always_comb begin
    w_next      = r_state;
    w_mode_nx   = r_mode;
    w_timer_nx  = r_timer;
    w_timer_inc = sat_inc(r_timer);
    if (w_conflict || w_fill_fault) begin
      w_next     = FAULT;
      w_timer_nx = '0;
    end else if (tick) begin
      unique case (r_state)
        IDLE: begin
          if (!w_earth && w_low) begin
            w_mode_nx  = (!w_air && !w_cold && w_mid) ? SPRINKLE : DRIP;
            w_next     = DEAD;
            w_timer_nx = '0;
          end
        end
        DEAD: begin
          if (w_timer_inc >= DEAD_T) begin
            w_next     = r_mode;
            w_timer_nx = '0;
          end else begin
            w_timer_nx = w_timer_inc;
          end
        end
        SPRINKLE, DRIP: begin
          if (w_timer_inc >= RUN_T || w_earth || !w_low) begin
            w_next     = SOAK;
            w_timer_nx = '0;
          end else begin
            w_timer_nx = w_timer_inc;
          end
        end
        SOAK: begin
          if (w_timer_inc >= SOAK_T) begin
            w_next     = IDLE;
            w_timer_nx = '0;
          end else begin
            w_timer_nx = w_timer_inc;
          end
        end
        FAULT: begin
          w_next     = IDLE;
          w_timer_nx = '0;
        end
        default: begin
          w_next     = IDLE;
          w_timer_nx = '0;
        end
      endcase
    end
  end

  // Outputs are registered from the next state so they line up with state_code
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      r_state <= IDLE;
      r_mode  <= DRIP;
      r_timer <= '0;
      r_valve <= 1'b0;
      r_spk   <= 1'b0;
      r_drip  <= 1'b0;
      r_alarm <= 1'b0;
    end else begin
      r_state <= w_next;
      r_mode  <= w_mode_nx;
      r_timer <= w_timer_nx;
      r_valve <= ~w_high & ~w_conflict & (w_next != FAULT);
      r_spk   <= (w_next == SPRINKLE);
      r_drip  <= (w_next == DRIP);
      r_alarm <= (w_next == FAULT) | ~w_mid;
    end
  end

  assign water_supply_valvule = r_valve;
  assign splinker_bomb        = r_spk;
  assign dripper_valvule      = r_drip;
  assign alarm                = r_alarm;
  assign state_code           = r_state;

endmodule

// File: tb/tb_irrigation_sequencer.sv
// Self-checking bench for irrigation_sequencer: directed scenarios then random sensor activity,
// compared every tick against a tick-level behavioural model.
module tb_irrigation_sequencer;

  localparam int DEB   = 3;
  localparam int RUN   = 8;
  localparam int DEADT = 2;
  localparam int SOAKT = 4;
  localparam int FILLT = 16;

  logic       clock = 1'b0;
  logic       reset_n = 1'b0;
  logic       tick = 1'b0;
  logic       low = 1'b0, mid = 1'b0, high = 1'b0, earth = 1'b0, air = 1'b0, cold = 1'b0;
  logic       valve, spk, drip, alarm;
  logic [2:0] sc;

  int total = 0;
  int bad   = 0;

  always #5 clock = ~clock;

  irrigation_sequencer #(
    .DEBOUNCE_TICKS(DEB),
    .RUN_TICKS(RUN),
    .DEAD_TICKS(DEADT),
    .SOAK_TICKS(SOAKT),
    .TIMER_WIDTH(8)
`ifdef FILL_TIMEOUT_EN
    ,.FILL_TIMEOUT_TICKS(FILLT)
`endif
  ) dut (
    .clock(clock),
    .reset_n(reset_n),
    .tick(tick),
    .low_water_level(low),
    .mid_water_level(mid),
    .high_water_level(high),
    .earth_humidity(earth),
    .air_humidity(air),
    .low_temperature(cold),
    .water_supply_valvule(valve),
    .splinker_bomb(spk),
    .dripper_valvule(drip),
    .alarm(alarm),
    .state_code(sc)
  );

  // Behavioural model, one update per tick. Sensor order: 0 low,1 mid,2 high,3 earth,4 air,5 cold
  int       m_state, m_mode, m_el, m_fill;
  bit       m_ff;
  bit [5:0] m_deb;
  int       m_cnt [6];

  function automatic bit conflict_of(input bit [5:0] d);
    return (d[1] && !d[0]) || (d[2] && !d[1]);
  endfunction

  function automatic bit exp_valve();
    return !m_deb[2] && !conflict_of(m_deb) && (m_state != 5);
  endfunction

  task automatic model_reset();
    m_state = 0; m_mode = 3; m_el = 0; m_fill = 0; m_ff = 0; m_deb = '0;
    for (int i = 0; i < 6; i++) m_cnt[i] = 0;
  endtask

  task automatic model_tick();
    bit [5:0] raw;
    bit [5:0] d;
    bit       ff_old;
    raw    = {cold, air, earth, high, mid, low};
    d      = m_deb;
    ff_old = m_ff;
`ifdef FILL_TIMEOUT_EN
    if (exp_valve()) begin
      m_fill++;
      if (m_fill >= FILLT) m_ff = 1;
    end else m_fill = 0;
`endif
    if (conflict_of(d) || ff_old) begin
      m_state = 5; m_el = 0;
    end else begin
      case (m_state)
        0: if (!d[3] && d[0]) begin
             m_mode = (!d[4] && !d[5] && d[1]) ? 2 : 3;
             m_state = 1; m_el = 0;
           end
        1: begin m_el++; if (m_el >= DEADT) begin m_state = m_mode; m_el = 0; end end
        2, 3: begin m_el++; if (m_el >= RUN || d[3] || !d[0]) begin m_state = 4; m_el = 0; end end
        4: begin m_el++; if (m_el >= SOAKT) begin m_state = 0; m_el = 0; end end
        default: begin m_state = 0; m_el = 0; end
      endcase
    end
    for (int i = 0; i < 6; i++) begin
      if (raw[i] != m_deb[i]) begin
        m_cnt[i]++;
        if (m_cnt[i] >= DEB) begin m_deb[i] = ~m_deb[i]; m_cnt[i] = 0; end
      end else m_cnt[i] = 0;
    end
    // Conflict or a fill fault between ticks forces FAULT within one clock
    if (conflict_of(m_deb) || m_ff) begin m_state = 5; m_el = 0; end
  endtask

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_model(input int n);
    chk($sformatf("valve@%0d", n), 8'(valve), 8'(exp_valve()));
    chk($sformatf("spk@%0d", n),   8'(spk),   8'(m_state == 2));
    chk($sformatf("drip@%0d", n),  8'(drip),  8'(m_state == 3));
    chk($sformatf("alarm@%0d", n), 8'(alarm), 8'((m_state == 5) || !m_deb[1]));
    chk($sformatf("state@%0d", n), 8'(sc),    8'(m_state));
  endtask

  int stepno = 0;

  // Inputs settle through the synchroniser before the tick; sample two clocks after it
  task automatic step();
    repeat (3) @(negedge clock);
    tick = 1'b1;
    @(negedge clock);
    tick = 1'b0;
    model_tick();
    repeat (2) @(negedge clock);
    stepno++;
    check_model(stepno);
  endtask

  task automatic reset_pulse();
    @(negedge clock);
    reset_n = 1'b0;
    @(negedge clock);
    reset_n = 1'b1;
    chk("rst_valve", 8'(valve), 8'd0);
    chk("rst_spk",   8'(spk),   8'd0);
    chk("rst_drip",  8'(drip),  8'd0);
    chk("rst_alarm", 8'(alarm), 8'd0);
    chk("rst_state", 8'(sc),    8'd0);
    model_reset();
  endtask

  task automatic set_in(input logic l, m, h, e, a, c);
    low = l; mid = m; high = h; earth = e; air = a; cold = c;
  endtask

  initial begin
    int spk_cnt, drip_cnt, r;
    // Reset state
    repeat (4) @(negedge clock);
    chk("init_valve", 8'(valve), 8'd0);
    chk("init_spk",   8'(spk),   8'd0);
    chk("init_drip",  8'(drip),  8'd0);
    chk("init_alarm", 8'(alarm), 8'd0);
    chk("init_state", 8'(sc),    8'd0);
    model_reset();
    reset_n = 1'b1;

    // All sensors low: idle, alarm on (mid=0), valve open
    repeat (5) step();
    chk("idle_alarm", 8'(alarm), 8'd1);
    chk("idle_valve", 8'(valve), 8'd1);

    // Sprinkle path
    set_in(1, 1, 0, 0, 0, 0);
    spk_cnt = 0; drip_cnt = 0;
    repeat (20) begin
      step();
      if (spk === 1'b1) spk_cnt++;
      if (drip === 1'b1) drip_cnt++;
    end
`ifndef FILL_TIMEOUT_EN
    chk("spk_run_len", 8'(spk_cnt), 8'(RUN));
`endif
    chk("spk_no_drip", 8'(drip_cnt), 8'd0);

    // Drip path with earth glitch and a real earth rise
    reset_pulse();
    set_in(1, 1, 0, 0, 0, 1);
    repeat (6) step();
    chk("drip_start", 8'(sc), 8'd3);
    earth = 1'b1;
    repeat (2) step();
    earth = 1'b0;
    step();
    chk("glitch_ignored", 8'(sc), 8'd3);
    earth = 1'b1;
    repeat (4) step();
    chk("earth_soak", 8'(sc), 8'd4);
    repeat (2) step();

    // Level conflict: mid without low
    low = 1'b0;
    repeat (3) step();
    chk("fault_state", 8'(sc),    8'd5);
    chk("fault_alarm", 8'(alarm), 8'd1);
    chk("fault_valve", 8'(valve), 8'd0);
    chk("fault_act",   8'({spk, drip}), 8'd0);
    low = 1'b1;
    repeat (3) step();
    chk("fault_hold", 8'(sc), 8'd5);
    step();
`ifdef FILL_TIMEOUT_EN
    chk("fill_sticky_state", 8'(sc),    8'd5);
    chk("fill_sticky_alarm", 8'(alarm), 8'd1);
`else
    chk("fault_exit", 8'(sc), 8'd0);
`endif

    // Reset in the middle of a sprinkle run
    reset_pulse();
    set_in(1, 1, 0, 0, 0, 0);
    for (int k = 0; k < 20; k++) begin
      step();
      if (sc === 3'd2) break;
    end
    chk("reach_sprinkle", 8'(sc), 8'd2);
    reset_pulse();

    // Random sensor activity
    for (int k = 0; k < 250; k++) begin
      r = $urandom_range(0, 39);
      if (r == 0) reset_pulse();
      else if (r < 16) begin
        case ($urandom_range(0, 5))
          0: low   = ~low;
          1: mid   = ~mid;
          2: high  = ~high;
          3: earth = ~earth;
          4: air   = ~air;
          default: cold = ~cold;
        endcase
      end
      step();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
